// File: rtl/nrisc_dmem_arbiter.sv
// Two-master round-robin arbiter for the NRISC data memory with a
// variable-latency ready handshake and a per-access timeout watchdog.
module nrisc_dmem_arbiter #(
  parameter int TAM     = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [TAM-1:0]    a_wdata,
  output logic [TAM-1:0]    a_rdata,
  output logic              a_ack,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [TAM-1:0]    b_wdata,
  output logic [TAM-1:0]    b_rdata,
  output logic              b_ack,
  output logic              b_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [TAM-1:0]    mem_wdata,
  input  logic [TAM-1:0]    mem_rdata,
  input  logic              mem_ready,
  output logic              owner,
  output logic              timeout_flag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [TAM-1:0]    mem_wdata_q, mem_wdata_d;
  logic [TAM-1:0]    a_rdata_q, a_rdata_d;
  logic [TAM-1:0]    b_rdata_q, b_rdata_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic              flag_q, flag_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              grant;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    owner_d     = owner_q;
    err_d       = err_q;
    flag_d      = flag_q;
    cnt_d       = cnt_q;
    grant       = (a_req && b_req) ? ~owner_q : b_req;

    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          owner_d     = grant;
          mem_we_d    = grant ? b_we    : a_we;
          mem_addr_d  = grant ? b_addr  : a_addr;
          mem_wdata_d = grant ? b_wdata : a_wdata;
          cnt_d       = 8'd0;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          err_d   = 1'b0;
          state_d = S_DONE;
          if (!mem_we_q) begin
            if (owner_q) b_rdata_d = mem_rdata;
            else         a_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          // Exit is guaranteed at TIMEOUT, so the counter never needs to wrap.
          if (cnt_d == TIMEOUT_C) begin
            err_d   = 1'b1;
            flag_d  = 1'b1;
            state_d = S_DONE;
            if (!mem_we_q) begin
              if (owner_q) b_rdata_d = '1;
              else         a_rdata_d = '1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      owner_q     <= 1'b1;
      err_q       <= 1'b0;
      flag_q      <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      flag_q      <= flag_d;
      cnt_q       <= cnt_d;
    end
  end

  // Strobe and acks decode straight from state so reset drops them immediately.
  assign mem_en       = (state_q == S_BUSY);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign a_ack        = (state_q == S_DONE) && !owner_q;
  assign b_ack        = (state_q == S_DONE) &&  owner_q;
  assign a_err        = a_ack && err_q;
  assign b_err        = b_ack && err_q;
  assign a_rdata      = a_rdata_q;
  assign b_rdata      = b_rdata_q;
  assign owner        = owner_q;
  assign timeout_flag = flag_q;

endmodule
